// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle RV32M multiply/divide controller for the ex stage.
// Multiplies use shift-add and divides use restoring shift-subtract, one bit per cycle.
// Optional feature: define MDU_FAST_MUL_EN for single-cycle multiplies.
module mdu_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [4:0]      w_reg_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      w_reg_addr_o
);

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpRem    = 3'b110;

    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      addr_q, addr_d;
    // a_q: multiplicand or divisor magnitude; hi_q/lo_q: product or remainder/quotient pair
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_q, neg_d;   // product or quotient is negative
    logic            rneg_q, rneg_d; // remainder is negative

    // Start-edge decode
    logic            s1_signed, s2_signed, s1_neg, s2_neg;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic            fast_mul;
    logic [XLEN-1:0] fast_res;

    // Iteration datapath
    logic [XLEN:0]     mul_sum, div_shl, div_sub;
    logic              div_ge;
    logic [XLEN-1:0]   it_hi, it_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_res;

    // Decode signedness, magnitudes and special cases of the incoming request
    always_comb begin
        s1_signed = (op_i == OpMulh) || (op_i == OpMulhsu) || (op_i == OpDiv) || (op_i == OpRem);
        s2_signed = (op_i == OpMulh) || (op_i == OpDiv) || (op_i == OpRem);
        s1_neg    = s1_signed && src1_i[XLEN-1];
        s2_neg    = s2_signed && src2_i[XLEN-1];
        mag1      = s1_neg ? -src1_i : src1_i;
        mag2      = s2_neg ? -src2_i : src2_i;
        div_zero  = op_i[2] && (src2_i == '0);
        div_ovf   = op_i[2] && !op_i[0] && (src1_i == IntMin) && (src2_i == '1);
        special   = div_zero || div_ovf;
        if (div_zero) begin
            special_res = op_i[1] ? src1_i : '1;
        end else begin
            special_res = op_i[1] ? '0 : IntMin;
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_p;

    // Sign-extend to 33 bits so one signed multiplier covers all four multiply flavours
    always_comb begin
        fast_a   = $signed({s1_signed & src1_i[XLEN-1], src1_i});
        fast_b   = $signed({s2_signed & src2_i[XLEN-1], src2_i});
        fast_p   = fast_a * fast_b;
        fast_mul = !op_i[2];
        fast_res = (op_i == OpMul) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    end
`else
    assign fast_mul = 1'b0;
    assign fast_res = '0;
`endif

    // One shift-add or shift-subtract step, plus the signed result of the final step
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        // Remainder stays below the divisor, so bit XLEN of div_sub is a clean borrow flag
        div_shl = {hi_q, lo_q[XLEN-1]};
        div_sub = div_shl - {1'b0, a_q};
        div_ge  = !div_sub[XLEN];
        if (op_q[2]) begin
            it_hi = div_ge ? div_sub[XLEN-1:0] : div_shl[XLEN-1:0];
            it_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            it_hi = mul_sum[XLEN:1];
            it_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod   = {it_hi, it_lo};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -it_lo : it_lo;
        rem_s  = rneg_q ? -it_hi : it_hi;
        if (op_q[2]) begin
            final_res = op_q[1] ? rem_s : quo_s;
        end else begin
            final_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state: capture on accepted start, iterate in CALC, flush wins everywhere
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        addr_d   = addr_q;
        a_d      = a_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_d   = op_i;
                        addr_d = w_reg_addr_i;
                        cnt_d  = '0;
                        hi_d   = '0;
                        neg_d  = s1_neg ^ s2_neg;
                        rneg_d = s1_neg;
                        if (op_i[2]) begin
                            a_d  = mag2;
                            lo_d = mag1;
                        end else begin
                            a_d  = mag1;
                            lo_d = mag2;
                        end
                        if (special) begin
                            result_d = special_res;
                            state_d  = StDone;
                        end else if (fast_mul) begin
                            result_d = fast_res;
                            state_d  = StDone;
                        end else begin
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    hi_d  = it_hi;
                    lo_d  = it_lo;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_d = final_res;
                        state_d  = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            a_q      <= a_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign stall_o      = ((state_q == StIdle) && start_i && !flush_i) || (state_q == StCalc);
    // A flush in the DONE cycle kills the instruction that owns the result
    assign done_o       = (state_q == StDone) && !flush_i;
    assign result_o     = result_q;
    assign w_reg_addr_o = addr_q;

endmodule
